// File: rtl/pwl_act_pipe.sv
// Three-stage piecewise-linear activation: segment select, slope multiply, bias/symmetry/saturate.
// Segment table is runtime-loadable, and writes are taken only while the pipeline is empty.
module pwl_act_pipe #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 9,
    parameter int SEG        = 32,
    parameter int SLOPE_W    = 16,
    parameter int SLOPE_FRAC = 8
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic signed [DATA_W-1:0]                             in_x,
    input  logic [1:0]                                           in_mode,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic signed [DATA_W-1:0]                             out_y,
    input  logic                                                 cfg_we,
    input  logic [$clog2(SEG)-1:0]                               cfg_addr,
    input  logic [1:0]                                           cfg_field,
    input  logic [((DATA_W > SLOPE_W) ? DATA_W : SLOPE_W)-1:0]   cfg_data,
    output logic                                                 busy
);

    localparam int IDX_W  = $clog2(SEG);
    localparam int PROD_W = DATA_W + 1 + SLOPE_W;
    localparam logic signed [DATA_W-1:0] X_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] X_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [PROD_W:0]   W_MAX = {{(PROD_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W:0]   W_MIN = {{(PROD_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [PROD_W:0]   W_ONE = {{(PROD_W-FRAC_W){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [PROD_W:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > W_MAX) begin
            r = W_MAX[DATA_W-1:0];
        end else if (v < W_MIN) begin
            r = W_MIN[DATA_W-1:0];
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

    logic signed [DATA_W-1:0]  bp_tab    [SEG];
    logic signed [DATA_W-1:0]  base_tab  [SEG];
    logic signed [SLOPE_W-1:0] slope_tab [SEG];
    logic signed [DATA_W-1:0]  bias_tab  [SEG];

    logic                      en_s;
    logic                      cfg_ok_s;
    logic                      fold_s;
    logic signed [DATA_W-1:0]  x_eff_s;
    logic [IDX_W-1:0]          idx_s;
    logic signed [DATA_W:0]    diff_s;
    logic signed [SLOPE_W-1:0] slope_sel_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [PROD_W-1:0]  shifted_s;
    logic signed [PROD_W:0]    sum_s;
    logic signed [DATA_W-1:0]  f_s;
    logic signed [PROD_W:0]    f_w_s;
    logic signed [PROD_W:0]    y_pre_s;
    logic signed [DATA_W-1:0]  y_s;

    logic                      v1_r, v2_r;
    logic signed [DATA_W-1:0]  x1_r;
    logic [IDX_W-1:0]          idx1_r, idx2_r;
    logic                      sig1_r, odd1_r, sig2_r, odd2_r;
    logic signed [PROD_W-1:0]  prod2_r;

    assign en_s     = ~out_valid | out_ready;
    assign in_ready = en_s & ~cfg_we;
    assign busy     = v1_r | v2_r | out_valid;
    assign cfg_ok_s = cfg_we & ~busy;

    // S1: fold negative inputs for symmetric modes, then pick the highest segment whose breakpoint is met
    always_comb begin
        fold_s = ((in_mode == 2'd1) || (in_mode == 2'd2)) && in_x[DATA_W-1];
        if (fold_s) begin
            x_eff_s = (in_x == X_MIN) ? X_MAX : -in_x;
        end else begin
            x_eff_s = in_x;
        end
        idx_s = '0;
        for (int i = 1; i < SEG; i++) begin
            idx_s = (x_eff_s >= bp_tab[i]) ? IDX_W'(i) : idx_s;
        end
    end

    // S2/S3 arithmetic: widths are kept full until the final saturations
    always_comb begin
        diff_s      = {x1_r[DATA_W-1], x1_r} - {base_tab[idx1_r][DATA_W-1], base_tab[idx1_r]};
        slope_sel_s = slope_tab[idx1_r];
        prod_s      = PROD_W'(diff_s) * PROD_W'(slope_sel_s);
        shifted_s   = prod2_r >>> SLOPE_FRAC;
        sum_s       = (PROD_W+1)'(shifted_s) + (PROD_W+1)'(bias_tab[idx2_r]);
        f_s         = sat_data(sum_s);
        f_w_s       = (PROD_W+1)'(f_s);
        if (sig2_r) begin
            y_pre_s = W_ONE - f_w_s;
        end else if (odd2_r) begin
            y_pre_s = -f_w_s;
        end else begin
            y_pre_s = f_w_s;
        end
        y_s = sat_data(y_pre_s);
    end

    // Segment table: cleared on reset, written only when no sample is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SEG; i++) begin
                bp_tab[i]    <= '0;
                base_tab[i]  <= '0;
                slope_tab[i] <= '0;
                bias_tab[i]  <= '0;
            end
        end else if (cfg_ok_s) begin
            case (cfg_field)
                2'd0:    bp_tab[cfg_addr]    <= cfg_data[DATA_W-1:0];
                2'd1:    base_tab[cfg_addr]  <= cfg_data[DATA_W-1:0];
                2'd2:    slope_tab[cfg_addr] <= cfg_data[SLOPE_W-1:0];
                default: bias_tab[cfg_addr]  <= cfg_data[DATA_W-1:0];
            endcase
        end
    end

    // Pipeline registers: every stage moves together on en_s so a stalled output freezes the whole pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            x1_r      <= '0;
            idx1_r    <= '0;
            idx2_r    <= '0;
            sig1_r    <= 1'b0;
            odd1_r    <= 1'b0;
            sig2_r    <= 1'b0;
            odd2_r    <= 1'b0;
            prod2_r   <= '0;
        end else if (en_s) begin
            v1_r      <= in_valid & in_ready;
            x1_r      <= x_eff_s;
            idx1_r    <= idx_s;
            sig1_r    <= (in_mode == 2'd1) && in_x[DATA_W-1];
            odd1_r    <= (in_mode == 2'd2) && in_x[DATA_W-1];
            v2_r      <= v1_r;
            prod2_r   <= prod_s;
            idx2_r    <= idx1_r;
            sig2_r    <= sig1_r;
            odd2_r    <= odd1_r;
            out_valid <= v2_r;
            out_y     <= y_s;
        end else begin
            v1_r      <= v1_r;
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// Scoreboard bench for pwl_act_pipe: expected results come from an arithmetic model of the
// segment table and are queued at accept time; a negedge monitor pops and compares outputs.
module tb_pwl_act_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = 16'h0000;
    logic [1:0]  in_mode = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_y;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = 5'd0;
    logic [1:0]  cfg_field = 2'd0;
    logic [15:0] cfg_data = 16'h0000;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int m_bp[32], m_base[32], m_slope[32], m_bias[32];
    int exp_q[$];
    bit ovr_en = 1'b0;
    int ovr_val = 0;
    bit prev_stall = 1'b0;
    int prev_y = 0;
    bit full_seen = 1'b0;

    pwl_act_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int s16(input logic [15:0] d);
        return int'($signed(d));
    endfunction

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Reference: choose segment by scanning breakpoints, then y = slope*(x-base)/256 + bias with symmetry
    function automatic int model_y(input int x, input int mode);
        bit     neg = (x < 0);
        bit     folded = ((mode == 1) || (mode == 2)) && neg;
        int     xe = folded ? ((x == -32768) ? 32767 : -x) : x;
        int     seg = 0;
        longint prod;
        int     f;
        for (int s = 1; s < 32; s++) if (xe >= m_bp[s]) seg = s;
        prod = longint'(xe - m_base[seg]) * longint'(m_slope[seg]);
        f = sat16((prod >>> 8) + longint'(m_bias[seg]));
        if (mode == 1 && neg) return sat16(longint'(512 - f));
        if (mode == 2 && neg) return sat16(-longint'(f));
        return f;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%04h) expected %0d (0x%04h) at %0t",
                     name, act, act[15:0], exp, exp[15:0], $time);
        end
    endtask

    // Monitor: protocol checks, model-table tracking, scoreboard push on accept and pop on output
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
            for (int s = 0; s < 32; s++) begin
                m_bp[s] = 0; m_base[s] = 0; m_slope[s] = 0; m_bias[s] = 0;
            end
        end else begin
            check("busy", int'(busy), int'(exp_q.size() != 0));
            check("in_ready", int'(in_ready), int'(!(out_valid && !out_ready) && !cfg_we));
            if (prev_stall) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_y", s16(out_y), prev_y);
            end
            if (!in_ready && !cfg_we && out_valid && !out_ready && exp_q.size() == 3) full_seen = 1'b1;
            if (cfg_we && exp_q.size() == 0) begin
                case (cfg_field)
                    2'd0:    m_bp[cfg_addr]    = s16(cfg_data);
                    2'd1:    m_base[cfg_addr]  = s16(cfg_data);
                    2'd2:    m_slope[cfg_addr] = s16(cfg_data);
                    default: m_bias[cfg_addr]  = s16(cfg_data);
                endcase
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", s16(out_y), 99999);
                end else begin
                    check("out_y", s16(out_y), exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ovr_en ? ovr_val : model_y(s16(in_x), int'(in_mode)));
                ovr_en = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            prev_y = s16(out_y);
        end
    end

    task automatic cfg_write(input int field, input int addr, input logic [15:0] data);
        cfg_field = 2'(field);
        cfg_addr  = 5'(addr);
        cfg_data  = data;
        cfg_we    = 1'b1;
        @(posedge clk); #1;
        cfg_we    = 1'b0;
    endtask

    task automatic prog_all(input logic [15:0] bp, input logic [15:0] base,
                            input logic [15:0] slope, input logic [15:0] bias);
        for (int s = 1; s < 32; s++) begin
            cfg_write(0, s, bp);
            cfg_write(1, s, base);
            cfg_write(2, s, slope);
            cfg_write(3, s, bias);
        end
    endtask

    task automatic send(input logic [15:0] x, input int mode);
        bit ok = 1'b0;
        in_x = x;
        in_mode = 2'(mode);
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic send_exp(input logic [15:0] x, input int mode, input logic [15:0] e);
        ovr_val = s16(e);
        ovr_en = 1'b1;
        send(x, mode);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    function automatic logic [15:0] rand_x();
        case ($urandom % 8)
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // zeroed table, plus 3-cycle latency
        send_exp(16'h0200, 0, 16'h0000);
        check("lat_c1", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_c2", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_c3", int'(out_valid), 1);
        drain();

        prog_all(16'h0000, 16'h0000, 16'h0080, 16'h0100);
        send_exp(16'h0200, 0, 16'h0200);
        send_exp(16'hFE00, 0, 16'h0000);
        send_exp(16'hFF00, 1, 16'h0080);
        send_exp(16'hFF00, 2, 16'hFE80);
        send_exp(16'hFF00, 0, 16'h0000);
        send_exp(16'h0200, 3, 16'h0200);
        drain();

        prog_all(16'h0000, 16'h0000, 16'h7FFF, 16'h7000);
        send_exp(16'h7FFF, 0, 16'h7FFF);
        drain();
        for (int s = 1; s < 32; s++) cfg_write(2, s, 16'h8000);
        send_exp(16'h7FFF, 0, 16'h8000);
        send_exp(16'h8000, 2, 16'h7FFF);
        drain();

        // 8-sample stream with output stalled for five cycles
        prog_all(16'h0000, 16'h0000, 16'h0080, 16'h0100);
        full_seen = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rand_x(), int'($urandom % 4));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("in_ready_drop_full", int'(full_seen), 1);

        // config write while busy must be ignored
        out_ready = 1'b0;
        send_exp(16'h0200, 0, 16'h0200);
        repeat (3) @(posedge clk);
        #1;
        cfg_write(3, 31, 16'h0000);
        drain();
        send_exp(16'h0200, 0, 16'h0200);
        drain();

        // reset mid-stream discards in-flight samples and clears the table
        out_ready = 1'b0;
        send(16'h0100, 0);
        send(16'h0300, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send_exp(16'h0200, 0, 16'h0000);
        drain();

        // randomized table and traffic
        for (int s = 0; s < 32; s++) begin
            cfg_write(0, s, 16'($urandom));
            cfg_write(1, s, 16'($urandom));
            cfg_write(2, s, ($urandom % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512));
            cfg_write(3, s, 16'($urandom));
        end
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom % 4) != 0;
            in_x      = rand_x();
            in_mode   = 2'($urandom % 4);
            out_ready = ($urandom % 4) != 0;
            cfg_we    = ($urandom % 16) == 0;
            cfg_addr  = 5'($urandom);
            cfg_field = 2'($urandom);
            cfg_data  = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
